// File: rtl/down_counter_timer.sv
// down_counter_timer
//
// Loadable N-bit down counter used as a programmable interval timer.
// A controller loads a start count through a valid/ready handshake, the
// counter decrements on enabled edges while running, and a registered
// one-cycle done pulse marks expiry. Every register updates on the
// falling edge of clock, and reset is asynchronous and active low.
//
// Build option:
//   DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
//     Undefined: one-shot. The terminal decrement clears count and the
//                FSM passes through DONE back to IDLE.
//     Defined:   periodic. The terminal decrement reloads the last loaded
//                value, the FSM stays in RUN, and done pulses once per
//                period. Only abort or reset return the block to IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a load; load_ready high, count holds
// RUN   | counting down on enabled edges; busy high
// DONE  | single expiry cycle after the terminal edge; done high, count 0

module down_counter_timer #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_valid,
  input  logic [N-1:0] load_value,
  output logic         load_ready,
  input  logic         enable,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [N-1:0] COUNT_ZERO = '0;
  localparam logic [N-1:0] COUNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic         done_q;
  logic         done_d;

  logic         load_accept;
  logic         load_is_zero;
  logic         count_terminal;
  logic         run_step;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  // The reload register is only read in periodic mode, so it exists only there.
  logic [N-1:0] reload_q;
  logic [N-1:0] reload_d;
`endif

  // Handshake and datapath qualifiers shared by the next-state logic.
  always_comb begin
    load_accept    = load_valid && (state_q == IDLE);
    load_is_zero   = (load_value == COUNT_ZERO);
    // A count of 0 should never be seen in RUN; it is folded into the
    // terminal case so a corrupted state cannot wrap to all ones.
    count_terminal = (count_q <= COUNT_ONE);
    run_step       = (state_q == RUN) && !abort && enable;
  end

  // Next state, next count and the next value of the done pulse.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    case (state_q)
      IDLE: begin
        if (load_accept) begin
          count_d = load_value;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          reload_d = load_value;
`endif
          if (load_is_zero) begin
            // Zero interval expires straight away, in either build.
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (abort) begin
          // Abort wins over everything: leave with count frozen, no pulse.
          state_d = IDLE;
        end else if (run_step) begin
          if (!count_terminal) begin
            count_d = count_q - COUNT_ONE;
          end else begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            count_d = reload_q;
            state_d = RUN;
            done_d  = 1'b1;
`else
            count_d = COUNT_ZERO;
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end

      DONE: begin
        // Loads offered here are ignored; load_ready is low in this state.
        state_d = IDLE;
        count_d = COUNT_ZERO;
      end

      default: begin
        state_d = IDLE;
        count_d = COUNT_ZERO;
      end
    endcase
  end

  // Falling-edge state register with asynchronous active-low clear.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= COUNT_ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  // Reload register captures each accepted start count.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      reload_q <= COUNT_ZERO;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // Status outputs are plain decodes of the registered state.
  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q == RUN);
    count      = count_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against
// a behavioural model of the timer.
`timescale 1ns/1ps

module tb_down_counter_timer;

  localparam int N = 4;

  logic         clock = 1'b1;
  logic         reset;
  logic         load_valid = 1'b0;
  logic [N-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic         abort = 1'b0;
  logic         load_ready;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int passed = 0;
  int total  = 0;
  bit checking = 1'b0;

  down_counter_timer #(.N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .enable     (enable),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Behavioural model: remaining count, whether a run is in progress,
  // whether the expiry cycle is in progress, and the pulse flag.
  int m_count    = 0;
  int m_reload   = 0;
  bit m_running  = 1'b0;
  bit m_expiring = 1'b0;
  bit m_pulse    = 1'b0;

  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      m_count = 0; m_reload = 0;
      m_running = 0; m_expiring = 0; m_pulse = 0;
    end else if (m_expiring) begin
      m_expiring = 0; m_pulse = 0; m_count = 0;
    end else if (m_running) begin
      m_pulse = 0;
      if (abort) m_running = 0;
      else if (enable) begin
        if (m_count == 1) begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          m_count = m_reload; m_pulse = 1;
`else
          m_count = 0; m_running = 0; m_expiring = 1; m_pulse = 1;
`endif
        end else m_count = m_count - 1;
      end
    end else begin
      m_pulse = 0;
      if (load_valid) begin
        m_count = int'(load_value);
        m_reload = int'(load_value);
        if (load_value == 0) begin m_expiring = 1; m_pulse = 1; end
        else m_running = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clock) begin
    if (checking) begin
      check("model_count", 32'(count), 32'(m_count));
      check("model_busy", 32'(busy), 32'(m_running));
      check("model_done", 32'(done), 32'(m_pulse));
      check("model_load_ready", 32'(load_ready), 32'(!m_running && !m_expiring));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input int c, input bit b, input bit d, input bit r);
    check({tag, "_count"}, 32'(count), 32'(c));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_ready"}, 32'(load_ready), 32'(r));
  endtask

  task automatic offer(input int v);
    load_valid = 1'b1;
    load_value = N'(v);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    checking = 1'b1;
    cyc();
    expect_out("reset_state", 0, 0, 0, 1);

`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    // Load 4, enable high: 4,3,2,1,0 then one done cycle.
    offer(4); enable = 1'b1;
    cyc(); expect_out("l4_e0", 4, 1, 0, 0); load_valid = 1'b0;
    cyc(); expect_out("l4_e1", 3, 1, 0, 0);
    cyc(); expect_out("l4_e2", 2, 1, 0, 0);
    cyc(); expect_out("l4_e3", 1, 1, 0, 0);
    cyc(); expect_out("l4_e4", 0, 0, 1, 0);
    cyc(); expect_out("l4_e5", 0, 0, 0, 1);

    // Load 3 with enable low for two edges: done 5 edges after accept.
    offer(3);
    cyc(); expect_out("l3_e0", 3, 1, 0, 0); load_valid = 1'b0;
    cyc(); expect_out("l3_e1", 2, 1, 0, 0); enable = 1'b0;
    cyc(); expect_out("l3_e2", 2, 1, 0, 0);
    cyc(); expect_out("l3_e3", 2, 1, 0, 0); enable = 1'b1;
    cyc(); expect_out("l3_e4", 1, 1, 0, 0);
    cyc(); expect_out("l3_e5", 0, 0, 1, 0);
    cyc(); expect_out("l3_e6", 0, 0, 0, 1);
`else
    // Periodic mode: load 3 gives count 3,2,1,3,2,1 with done on reloads.
    offer(3); enable = 1'b1;
    cyc(); expect_out("ar_e0", 3, 1, 0, 0); load_valid = 1'b0;
    cyc(); expect_out("ar_e1", 2, 1, 0, 0);
    cyc(); expect_out("ar_e2", 1, 1, 0, 0);
    cyc(); expect_out("ar_e3", 3, 1, 1, 0);
    cyc(); expect_out("ar_e4", 2, 1, 0, 0);
    cyc(); expect_out("ar_e5", 1, 1, 0, 0);
    cyc(); expect_out("ar_e6", 3, 1, 1, 0); abort = 1'b1;
    cyc(); expect_out("ar_abort", 3, 0, 0, 1); abort = 1'b0;
    // Abort together with the terminal decrement suppresses the pulse.
    offer(2);
    cyc(); expect_out("ar2_e0", 2, 1, 0, 0); load_valid = 1'b0;
    cyc(); expect_out("ar2_e1", 1, 1, 0, 0); abort = 1'b1;
    cyc(); expect_out("ar2_abort", 1, 0, 0, 1); abort = 1'b0;
`endif

    // Zero load: DONE next cycle; a load of 7 offered then waits one edge.
    enable = 1'b1;
    offer(0);
    cyc(); expect_out("z_done", 0, 0, 1, 0); offer(7);
    cyc(); expect_out("z_idle", 0, 0, 0, 1);
    cyc(); expect_out("z_load7", 7, 1, 0, 0); load_valid = 1'b0; abort = 1'b1;
    cyc(); expect_out("z_abort", 7, 0, 0, 1); abort = 1'b0;

    // Load 6, abort together with enable when count is 1.
    offer(6);
    cyc(); load_valid = 1'b0;
    repeat (5) cyc();
    expect_out("a6_at1", 1, 1, 0, 0); abort = 1'b1;
    cyc(); expect_out("a6_abort", 1, 0, 0, 1); abort = 1'b0;
    cyc(); expect_out("a6_after", 1, 0, 0, 1);

    // Asynchronous reset mid-run at count 5.
    offer(7);
    cyc(); load_valid = 1'b0;
    cyc(); cyc();
    expect_out("rst_pre", 5, 1, 0, 0);
    #2 reset = 1'b0;
    #1 expect_out("rst_async", 0, 0, 0, 1);
    cyc(); reset = 1'b1;
    cyc(); expect_out("rst_rel1", 0, 0, 0, 1);
    cyc(); expect_out("rst_rel2", 0, 0, 0, 1);

    // Randomized traffic checked by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      load_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       load_value = '0;
        1:       load_value = '1;
        2:       load_value = N'($urandom_range(0, (1 << N) - 1));
        default: load_value = N'($urandom_range(1, 5));
      endcase
      enable = ($urandom_range(0, 4) != 0);
      abort  = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 250) == 0) begin
        #2 reset = 1'b0;
        #1 expect_out("rnd_rst", 0, 0, 0, 1);
        cyc(); reset = 1'b1;
      end
    end

    load_valid = 1'b0; abort = 1'b0;
    cyc();
    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable N-bit synchronous down counter with a load handshake, enable-gated decrement, abort, and a one-cycle terminal-count pulse. It is the counting-down counterpart of the team's ripple up-counter. It is used as a programmable interval timer: a controller loads a count, the block decrements on enabled clock edges, and it signals expiry. All state updates occur on the falling edge of `clock`, matching the counter library's edge convention.

## Interface

Parameters:
- `N`, default 4: counter width in bits.

Ports:
- `clock`, input, 1: single clock. All registers update on the falling edge.
- `reset`, input, 1: asynchronous, active-low reset. It takes effect immediately when low and is released synchronously to the design by the next falling edge.
- `load_valid`, input, 1: the load request is valid.
- `load_value`, input, N: start count. It is sampled on the accept edge.
- `load_ready`, output, 1: the block can accept a load. High only in IDLE.
- `enable`, input, 1: decrement qualifier while running.
- `abort`, input, 1: cancels a run in progress.
- `count`, output, N: current count (registered).
- `busy`, output, 1: high in RUN.
- `done`, output, 1: registered expiry pulse, one cycle wide.

## Operation

- FSM states are IDLE, RUN and DONE. `load_ready` = (state == IDLE) and `busy` = (state == RUN); both are decoded from state.
- Reset (`reset` low): state = IDLE, `count` = 0, `done` = 0, the internal reload register = 0. As a result `load_ready` = 1 and `busy` = 0. This applies at any time, including mid-run, with no `done` pulse.
- IDLE:
  - A load is accepted at a falling edge where `load_valid` and `load_ready` are both high.
  - On accept: `count` ← `load_value` and the reload register ← `load_value`.
  - Next state is RUN if `load_value` ≠ 0. If `load_value` = 0, next state is DONE.
  - Without an accepted load, `count` holds.
- RUN:
  - `abort` high → IDLE. `count` holds its current value and no `done` pulse is produced. `abort` has priority over everything else in RUN.
  - Otherwise, if `enable` is high and `count` > 1: `count` ← `count` − 1.
  - Otherwise, if `enable` is high and `count` = 1: this is the terminal decrement (behaviour defined under Configuration).
  - If `enable` is low: `count` holds.
- DONE: lasts exactly one cycle. `done` = 1 and `count` = 0. Next state is always IDLE. `load_valid` is ignored in this state.
- `abort` has no effect in IDLE or DONE. `enable` has no effect outside RUN.
- Arithmetic: the decrement is modulo 2^N, but `count` never wraps below 0 because the transition is taken at `count` = 1.
- `load_value` = 2^N − 1 gives the maximum interval.

## Timing

- Load accepted at edge E0 → `count` = L and `busy` = 1 from E0.
- With `enable` held high, `count` reaches 0 at edge E0+L. The `done` pulse is high from E0+L to E0+L+1, and `busy` is 0 during that cycle.
- `load_ready` returns high at E0+L+1. A new load can be accepted at E0+L+1 at the earliest.
- Each edge with `enable` low during RUN adds one cycle to the interval.
- A zero load gives `done` one cycle after accept, with `busy` never asserted.
- `done` never lasts more than one cycle per expiry.

## Configuration

- Macro: `DOWN_COUNTER_TIMER_AUTO_RELOAD_EN`.
- Undefined (default): at the terminal decrement, `count` ← 0 and state → DONE, as described above.
- Defined: at the terminal decrement, `count` ← reload register, the state stays RUN, and `done` pulses high for the following cycle while `busy` stays 1. This gives a periodic pulse every L enabled edges.
  - `abort` is the only way back to IDLE other than reset.
  - `abort` on the same edge as a terminal decrement suppresses that `done` pulse.
  - A zero load still goes IDLE → DONE → IDLE.

## Test plan

- Reset low mid-run with `count` = 5 → `count` = 0, `busy` = 0, `done` = 0 and `load_ready` = 1 immediately (asynchronously). No `done` pulse follows the release of reset.
- Load 4 with `enable` held high → `count` steps 4, 3, 2, 1, 0 on successive falling edges. `done` is high for exactly one cycle after 0 is reached, then `load_ready` = 1.
- Load 3 with `enable` low for 2 cycles mid-run → `count` holds during those cycles. `done` appears 5 edges after accept.
- Load 0 → the next cycle has `done` = 1 and `busy` = 0 throughout. A load of 7 offered during the DONE cycle is not accepted until the following edge.
- Load 6, then assert `abort` when `count` = 1 together with `enable` → state goes to IDLE, `count` = 1 holds, and no `done` pulse occurs.
- With `DOWN_COUNTER_TIMER_AUTO_RELOAD_EN` defined: load 3 with `enable` high → `done` pulses every 3 edges and `count` cycles 3, 2, 1, 3, 2, 1. `abort` stops the sequence and `busy` drops the next cycle.
